// File: rtl/current_pwm_driver.sv
// current_pwm_driver: complementary half-bridge PWM with dead time, driven by a signed current command.
// Commands are double-buffered so duty/direction only change at period boundaries.
module current_pwm_driver #(
    parameter int PERIOD = 2500,
    parameter int DEAD   = 25,
    parameter int CNT_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [31:0] i_current,
    input  logic               cmd_valid,
    output logic               pwm_h,
    output logic               pwm_l,
    output logic               dir,
    output logic               sat,
    output logic               period_start
);
    localparam logic [31:0] P = PERIOD;
    localparam logic [31:0] D = DEAD;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      shadow, mag, duty_next, act_duty, c;
    logic             act_dir, act_sat, load;

    always_comb begin
        mag       = shadow[31] ? -shadow : shadow;
        duty_next = (mag >= P) ? P : mag;
        load      = !en || cnt == LAST;
        c         = 32'(cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shadow   <= '0;
            act_duty <= '0;
            act_dir  <= 1'b0;
            act_sat  <= 1'b0;
        end else begin
            if (cmd_valid)
                shadow <= i_current;
            if (load) begin
                act_duty <= duty_next;
                act_dir  <= shadow[31];
                act_sat  <= mag > P;
            end
            cnt <= load ? '0 : cnt + 1'b1;
        end
    end

    // dir/sat are delayed with the gate decode so a direction flip lands in the dead band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            period_start <= 1'b0;
            dir          <= 1'b0;
            sat          <= 1'b0;
        end else begin
            pwm_h        <= en && c >= D && c < act_duty;
            pwm_l        <= en && c >= act_duty + D && c < P;
            period_start <= en && cnt == '0;
            dir          <= act_dir;
            sat          <= act_sat;
        end
    end
endmodule

// File: tb/tb_current_pwm_driver.sv
// tb_current_pwm_driver: table-driven check of per-period gate widths, plus corner sequences
// for coincident commands, async reset mid-pulse and enable drop.
module tb_current_pwm_driver;
    localparam int PERIOD = 2500;
    localparam int DEAD   = 25;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic signed [31:0] i_current = '0;
    logic               cmd_valid = 1'b0;
    logic               pwm_h, pwm_l, dir, sat, period_start;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    logic dir_q = 1'b0;

    current_pwm_driver #(.PERIOD(PERIOD), .DEAD(DEAD), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i_current(i_current), .cmd_valid(cmd_valid),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .dir(dir), .sat(sat), .period_start(period_start)
    );

    always #10 clk = ~clk;

    // gates never overlap, and dir only moves while both gates are off
    always @(negedge clk) begin
        if (rst_n) begin
            if (pwm_h && pwm_l) viol++;
            if (dir != dir_q && (pwm_h || pwm_l)) viol++;
        end
        dir_q = dir;
    end

    typedef struct {
        logic [31:0] cmd;
        int          h, l, hf, lf;
        bit          d, s;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps(input string name);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (period_start) ok = 1;
            else @(negedge clk);
        end
        chk({name, "_ps_timeout"}, int'(ok), 1);
    endtask

    task automatic send(input logic [31:0] v);
        i_current = v;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // measures one full period starting at the next period_start sample
    task automatic measure(input string name, input int eh, input int el, input int ehf,
                           input int elf, input bit ed, input bit es);
        int h = 0, l = 0, hf = -1, lf = -1, ps = 0;
        bit d, s, stable = 1;
        wait_ps(name);
        d = dir;
        s = sat;
        for (int k = 0; k < PERIOD; k++) begin
            if (pwm_h) begin h++; if (hf < 0) hf = k; end
            if (pwm_l) begin l++; if (lf < 0) lf = k; end
            if (period_start) ps++;
            if (dir != d || sat != s) stable = 0;
            @(negedge clk);
        end
        chk({name, "_h_width"}, h, eh);
        chk({name, "_l_width"}, l, el);
        chk({name, "_h_first"}, hf, ehf);
        chk({name, "_l_first"}, lf, elf);
        chk({name, "_ps_count"}, ps, 1);
        chk({name, "_dir"}, int'(d), int'(ed));
        chk({name, "_sat"}, int'(s), int'(es));
        chk({name, "_stable"}, int'(stable), 1);
    endtask

    initial begin
        vecs[0] = '{32'd1000,        975, 1475, 25, 1025, 1'b0, 1'b0};
        vecs[1] = '{-32'sd1000,      975, 1475, 25, 1025, 1'b1, 1'b0};
        vecs[2] = '{32'd3000,        2475, 0,   25, -1,   1'b0, 1'b1};
        vecs[3] = '{32'h80000000,    2475, 0,   25, -1,   1'b1, 1'b1};
        vecs[4] = '{32'd2500,        2475, 0,   25, -1,   1'b0, 1'b0};
        vecs[5] = '{32'd2475,        2450, 0,   25, -1,   1'b0, 1'b0};
        vecs[6] = '{32'd0,           0,   2475, -1, 25,   1'b0, 1'b0};
        vecs[7] = '{32'd10,          0,   2465, -1, 35,   1'b0, 1'b0};
        vecs[8] = '{32'd25,          0,   2450, -1, 50,   1'b0, 1'b0};
        vecs[9] = '{-32'sd26,        1,   2449, 25, 51,   1'b1, 1'b0};

        @(negedge clk);
        chk("rst_outputs", int'({pwm_h, pwm_l, dir, sat, period_start}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", int'({pwm_h, pwm_l, dir, sat, period_start}), 0);
        en = 1'b1;
        @(negedge clk);
        chk("first_ps", int'(period_start), 1);

        foreach (vecs[i]) begin
            send(vecs[i].cmd);
            wait_ps($sformatf("v%0d_skip", i));
            @(negedge clk);
            measure($sformatf("v%0d", i), vecs[i].h, vecs[i].l, vecs[i].hf, vecs[i].lf,
                    vecs[i].d, vecs[i].s);
        end

        // 500 mid-period, then 1500 on the cnt=2499 load edge
        wait_ps("coinc_sync");
        i_current = 32'd500;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2497) @(negedge clk);
        send(32'd1500);
        measure("coinc_500", 475, 1975, 25, 525, 1'b0, 1'b0);
        measure("coinc_1500", 1475, 975, 25, 1525, 1'b0, 1'b0);

        // async reset at cnt=300 while pwm_h is high
        send(32'd1000);
        wait_ps("rst_skip");
        @(negedge clk);
        wait_ps("rst_sync");
        repeat (299) @(negedge clk);
        chk("pre_rst_h", int'(pwm_h), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", int'({pwm_h, pwm_l, dir, sat, period_start}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_restart_ps", int'(period_start), 1);
        measure("post_rst0", 0, 2475, -1, 25, 1'b0, 1'b0);
        measure("post_rst1", 0, 2475, -1, 25, 1'b0, 1'b0);

        // drop en mid-period while pwm_l is high; active tracks shadow while disabled
        repeat (1000) @(negedge clk);
        chk("pre_dis_l", int'(pwm_l), 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_outputs", int'({pwm_h, pwm_l, period_start}), 0);
        send(32'd1000);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("reen_ps", int'(period_start), 1);
        measure("reen", 975, 1475, 25, 1025, 1'b0, 1'b0);

        chk("gate_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
